// File: rtl/id_issue_ctrl_pkg.sv
// rtl/id_issue_ctrl_pkg.sv - shared types and constants for the decode/execute issue controller
//
// Purpose: forwarding-select encodings, issue FSM states, the issue control
//   bundle captured by the ID/EX registers, and the scoreboard slot record.
// Ports: none (package).
package id_issue_ctrl_pkg;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } issue_state_e;

  typedef struct packed {
    logic       halt;
    logic       alu_src;
    logic [4:0] alu_op;
    logic [3:0] jmp_type;
    logic       reg_wrenable;
    logic [4:0] write_reg;
    logic       mem_wrenable;
    logic       mem_to_reg;
  } issue_ctrl_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] write_reg;
    logic       reg_wrenable;
    logic       mem_to_reg;
  } sb_slot_t;

  // A bubble is the all-zero bundle: no write, no jump, no memory, no halt.
  localparam issue_ctrl_t ISSUE_BUBBLE = '0;

  // True when a slot produces a register the consumer actually reads.
  // Register 0 is hardwired, so it never matches.
  function automatic logic src_hit(sb_slot_t slot, logic uses, logic [4:0] rs);
    return slot.valid && slot.reg_wrenable && (slot.write_reg != 5'd0) &&
           uses && (slot.write_reg == rs);
  endfunction

endpackage

// File: rtl/id_issue_ctrl_if.sv
// rtl/id_issue_ctrl_if.sv - decoder-to-issue and issue-to-ID/EX signal bundle
//
// Purpose: groups the decoded instruction, branch resolution, and the
//   registered issue bundle with its stall/halted status.
// Ports: none; modport master = decoder/pipeline side, slave = issue controller.
interface id_issue_ctrl_if #(
  parameter int PC_W = 5
);

  logic            dec_valid;
  logic [PC_W-1:0] dec_pc;
  logic            dec_halt;
  logic [4:0]      dec_rs1;
  logic [4:0]      dec_rs2;
  logic            dec_uses_rs1;
  logic            dec_uses_rs2;
  logic            dec_alu_src;
  logic [4:0]      dec_alu_op;
  logic [3:0]      dec_jmp_type;
  logic            dec_reg_wrenable;
  logic [4:0]      dec_write_reg;
  logic            dec_mem_wrenable;
  logic            dec_mem_to_reg;
  logic            ex_branch_taken;

  logic [PC_W-1:0] iss_pc;
  logic            iss_halt;
  logic            iss_alu_src;
  logic [4:0]      iss_alu_op;
  logic [3:0]      iss_jmp_type;
  logic            iss_reg_wrenable;
  logic [4:0]      iss_write_reg;
  logic            iss_mem_wrenable;
  logic            iss_mem_to_reg;
  logic [1:0]      iss_fwd_a;
  logic [1:0]      iss_fwd_b;
  logic            stall;
  logic            halted;

  modport master (
    output dec_valid, dec_pc, dec_halt, dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2,
           dec_alu_src, dec_alu_op, dec_jmp_type, dec_reg_wrenable, dec_write_reg,
           dec_mem_wrenable, dec_mem_to_reg, ex_branch_taken,
    input  iss_pc, iss_halt, iss_alu_src, iss_alu_op, iss_jmp_type, iss_reg_wrenable,
           iss_write_reg, iss_mem_wrenable, iss_mem_to_reg, iss_fwd_a, iss_fwd_b,
           stall, halted
  );

  modport slave (
    input  dec_valid, dec_pc, dec_halt, dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2,
           dec_alu_src, dec_alu_op, dec_jmp_type, dec_reg_wrenable, dec_write_reg,
           dec_mem_wrenable, dec_mem_to_reg, ex_branch_taken,
    output iss_pc, iss_halt, iss_alu_src, iss_alu_op, iss_jmp_type, iss_reg_wrenable,
           iss_write_reg, iss_mem_wrenable, iss_mem_to_reg, iss_fwd_a, iss_fwd_b,
           stall, halted
  );

endinterface

// File: rtl/id_hazard_scoreboard.sv
// rtl/id_hazard_scoreboard.sv - two-deep issue scoreboard with load-use and forwarding logic
//
// Purpose: slot E = instruction issued last cycle, slot M = two cycles ago.
//   Flags a load-use hazard against E and picks operand forwarding sources.
// Ports: clk, reset (sync, active-high); rs1_i/rs2_i/uses_rs*_i decoded sources;
//   issue_valid_i/issue_i bundle being issued this cycle; load_use_o;
//   fwd_a_o/fwd_b_o forwarding selects for the instruction being issued.
module id_hazard_scoreboard
  import id_issue_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic        uses_rs1_i,
  input  logic        uses_rs2_i,
  input  logic        issue_valid_i,
  input  issue_ctrl_t issue_i,
  output logic        load_use_o,
  output logic [1:0]  fwd_a_o,
  output logic [1:0]  fwd_b_o
);

  sb_slot_t e_q, e_d, m_q, m_d;

  function automatic logic [1:0] fwd_sel(sb_slot_t e, sb_slot_t m, logic uses, logic [4:0] rs);
    // A load in E cannot forward yet; that case is stalled, so fall through.
    if (src_hit(e, uses, rs) && !e.mem_to_reg) return FWD_EXMEM;
    else if (src_hit(m, uses, rs))             return FWD_MEMWB;
    else                                       return FWD_RF;
  endfunction

  always_comb begin
    e_d.valid        = issue_valid_i;
    e_d.write_reg    = issue_i.write_reg;
    e_d.reg_wrenable = issue_i.reg_wrenable;
    e_d.mem_to_reg   = issue_i.mem_to_reg;
    m_d              = e_q;
  end

  assign load_use_o = e_q.mem_to_reg &&
                      (src_hit(e_q, uses_rs1_i, rs1_i) || src_hit(e_q, uses_rs2_i, rs2_i));
  assign fwd_a_o    = fwd_sel(e_q, m_q, uses_rs1_i, rs1_i);
  assign fwd_b_o    = fwd_sel(e_q, m_q, uses_rs2_i, rs2_i);

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
    end
  end

endmodule

// File: rtl/id_issue_ctrl.sv
// rtl/id_issue_ctrl.sv - decode-side issue controller driving the ID/EX pipeline registers
//
// Purpose: issues decoded instructions with forwarding selects, inserts bubbles
//   on load-use hazards and taken branches, and drains then stops on halt.
// Ports: clk, reset (sync, active-high); bus (slave modport) carrying the
//   decoded instruction, ex_branch_taken, the registered iss_* bundle,
//   combinational stall and registered halted.
module id_issue_ctrl
  import id_issue_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int PC_W         = 5
) (
  input logic           clk,
  input logic           reset,
  id_issue_ctrl_if.slave bus
);

  localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  issue_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  issue_ctrl_t     iss_q, iss_d, dec_ctrl;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [1:0]      fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic            halted_q, halted_d;
  logic            issue_valid, stall_c, load_use;
  logic [1:0]      sb_fwd_a, sb_fwd_b;

  assign dec_ctrl = '{halt:         bus.dec_halt,
                      alu_src:      bus.dec_alu_src,
                      alu_op:       bus.dec_alu_op,
                      jmp_type:     bus.dec_jmp_type,
                      reg_wrenable: bus.dec_reg_wrenable,
                      write_reg:    bus.dec_write_reg,
                      mem_wrenable: bus.dec_mem_wrenable,
                      mem_to_reg:   bus.dec_mem_to_reg};

  id_hazard_scoreboard u_sb (
    .clk          (clk),
    .reset        (reset),
    .rs1_i        (bus.dec_rs1),
    .rs2_i        (bus.dec_rs2),
    .uses_rs1_i   (bus.dec_uses_rs1),
    .uses_rs2_i   (bus.dec_uses_rs2),
    .issue_valid_i(issue_valid),
    .issue_i      (iss_d),
    .load_use_o   (load_use),
    .fwd_a_o      (sb_fwd_a),
    .fwd_b_o      (sb_fwd_b)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    iss_d       = ISSUE_BUBBLE;
    pc_d        = '0;
    fwd_a_d     = FWD_RF;
    fwd_b_d     = FWD_RF;
    issue_valid = 1'b0;
    stall_c     = 1'b0;
    unique case (state_q)
      RUN: begin
        // A taken branch kills the decoder's instruction, so neither a hazard
        // stall nor a halt in that slot matters.
        if (!bus.ex_branch_taken && bus.dec_valid) begin
          if (load_use) begin
            stall_c = 1'b1;
          end else begin
            iss_d       = dec_ctrl;
            pc_d        = bus.dec_pc;
            fwd_a_d     = sb_fwd_a;
            fwd_b_d     = sb_fwd_b;
            issue_valid = 1'b1;
            if (bus.dec_halt) begin
              state_d = DRAIN;
              cnt_d   = CNT_W'(DRAIN_CYCLES);
            end
          end
        end
      end
      DRAIN: begin
        // The halt is committed; branch resolution is ignored from here on.
        stall_c = 1'b1;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = HALTED;
      end
      HALTED: stall_c = 1'b1;
      default: state_d = RUN;
    endcase
    halted_d = (state_d == HALTED);
    if (reset) stall_c = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      iss_q    <= ISSUE_BUBBLE;
      pc_q     <= '0;
      fwd_a_q  <= FWD_RF;
      fwd_b_q  <= FWD_RF;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      iss_q    <= iss_d;
      pc_q     <= pc_d;
      fwd_a_q  <= fwd_a_d;
      fwd_b_q  <= fwd_b_d;
      halted_q <= halted_d;
    end
  end

  assign bus.iss_pc           = pc_q;
  assign bus.iss_halt         = iss_q.halt;
  assign bus.iss_alu_src      = iss_q.alu_src;
  assign bus.iss_alu_op       = iss_q.alu_op;
  assign bus.iss_jmp_type     = iss_q.jmp_type;
  assign bus.iss_reg_wrenable = iss_q.reg_wrenable;
  assign bus.iss_write_reg    = iss_q.write_reg;
  assign bus.iss_mem_wrenable = iss_q.mem_wrenable;
  assign bus.iss_mem_to_reg   = iss_q.mem_to_reg;
  assign bus.iss_fwd_a        = fwd_a_q;
  assign bus.iss_fwd_b        = fwd_b_q;
  assign bus.stall            = stall_c;
  assign bus.halted           = halted_q;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// tb/tb_id_issue_ctrl.sv - directed self-checking bench for id_issue_ctrl
module tb_id_issue_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   passed = 0;
  int   total = 0;

  always #5 clk = ~clk;

  id_issue_ctrl_if #(.PC_W(5)) bus ();

  id_issue_ctrl #(.DRAIN_CYCLES(3), .PC_W(5)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] pc, input logic h,
                       input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic we, input logic [4:0] wr, input logic m2r);
    bus.dec_valid        = v;
    bus.dec_pc           = pc;
    bus.dec_halt         = h;
    bus.dec_rs1          = rs1;
    bus.dec_uses_rs1     = u1;
    bus.dec_rs2          = rs2;
    bus.dec_uses_rs2     = u2;
    bus.dec_alu_src      = 1'b0;
    bus.dec_alu_op       = pc;
    bus.dec_jmp_type     = 4'd0;
    bus.dec_reg_wrenable = we;
    bus.dec_write_reg    = wr;
    bus.dec_mem_wrenable = 1'b0;
    bus.dec_mem_to_reg   = m2r;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0);
    bus.dec_jmp_type = 4'd3;
    #1;
    total++; if (bus.stall !== 1'b0) $display("FAIL reset_stall_pre: got %0d exp 0", bus.stall); else passed++;
    tick();
    tick();
    total++; if (bus.iss_reg_wrenable !== 1'b0) $display("FAIL reset_reg_we: got %0d exp 0", bus.iss_reg_wrenable); else passed++;
    total++; if (bus.iss_jmp_type !== 4'd0) $display("FAIL reset_jmp: got %0d exp 0", bus.iss_jmp_type); else passed++;
    total++; if (bus.iss_pc !== 5'd0) $display("FAIL reset_pc: got %0d exp 0", bus.iss_pc); else passed++;
    total++; if (bus.iss_halt !== 1'b0) $display("FAIL reset_halt: got %0d exp 0", bus.iss_halt); else passed++;
    total++; if (bus.stall !== 1'b0) $display("FAIL reset_stall: got %0d exp 0", bus.stall); else passed++;
    total++; if (bus.halted !== 1'b0) $display("FAIL reset_halted: got %0d exp 0", bus.halted); else passed++;
    idle();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_load_use();
    drive(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1);
    total++; if (bus.stall !== 1'b0) $display("FAIL lu_load_stall: got %0d exp 0", bus.stall); else passed++;
    tick();
    total++; if (bus.iss_mem_to_reg !== 1'b1) $display("FAIL lu_load_m2r: got %0d exp 1", bus.iss_mem_to_reg); else passed++;
    drive(1'b1, 5'd2, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0);
    total++; if (bus.stall !== 1'b1) $display("FAIL lu_stall: got %0d exp 1", bus.stall); else passed++;
    tick();
    total++; if (bus.iss_pc !== 5'd0) $display("FAIL lu_bubble_pc: got %0d exp 0", bus.iss_pc); else passed++;
    total++; if (bus.iss_reg_wrenable !== 1'b0) $display("FAIL lu_bubble_we: got %0d exp 0", bus.iss_reg_wrenable); else passed++;
    total++; if (bus.stall !== 1'b0) $display("FAIL lu_stall_release: got %0d exp 0", bus.stall); else passed++;
    tick();
    total++; if (bus.iss_pc !== 5'd2) $display("FAIL lu_reissue_pc: got %0d exp 2", bus.iss_pc); else passed++;
    total++; if (bus.iss_fwd_a !== 2'd2) $display("FAIL lu_fwd_a: got %0d exp 2", bus.iss_fwd_a); else passed++;
    total++; if (bus.iss_alu_op !== 5'd2) $display("FAIL lu_alu_op: got %0d exp 2", bus.iss_alu_op); else passed++;
    idle();
    tick();
  endtask

  task automatic test_forwarding();
    drive(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0);
    tick();
    drive(1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 5'd8, 1'b0);
    total++; if (bus.stall !== 1'b0) $display("FAIL fwd_alu_stall: got %0d exp 0", bus.stall); else passed++;
    tick();
    total++; if (bus.iss_fwd_b !== 2'd1) $display("FAIL fwd_b_exmem: got %0d exp 1", bus.iss_fwd_b); else passed++;
    total++; if (bus.iss_fwd_a !== 2'd0) $display("FAIL fwd_a_unused: got %0d exp 0", bus.iss_fwd_a); else passed++;
    drive(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    total++; if (bus.iss_fwd_b !== 2'd2) $display("FAIL fwd_b_memwb: got %0d exp 2", bus.iss_fwd_b); else passed++;
    drive(1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    total++; if (bus.iss_fwd_b !== 2'd0) $display("FAIL fwd_b_dist3: got %0d exp 0", bus.iss_fwd_b); else passed++;
    drive(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1);
    tick();
    drive(1'b1, 5'd8, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd9, 1'b0);
    total++; if (bus.stall !== 1'b0) $display("FAIL fwd_r0_stall: got %0d exp 0", bus.stall); else passed++;
    tick();
    total++; if (bus.iss_pc !== 5'd8) $display("FAIL fwd_r0_pc: got %0d exp 8", bus.iss_pc); else passed++;
    total++; if (bus.iss_fwd_a !== 2'd0) $display("FAIL fwd_r0_a: got %0d exp 0", bus.iss_fwd_a); else passed++;
    drive(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0);
    tick();
    drive(1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0);
    tick();
    drive(1'b1, 5'd11, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    total++; if (bus.iss_fwd_a !== 2'd1) $display("FAIL fwd_e_priority: got %0d exp 1", bus.iss_fwd_a); else passed++;
    idle();
    tick();
  endtask

  task automatic test_flush();
    drive(1'b1, 5'd12, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1);
    tick();
    drive(1'b1, 5'd13, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd10, 1'b0);
    bus.ex_branch_taken = 1'b1;
    #1;
    total++; if (bus.stall !== 1'b0) $display("FAIL flush_stall: got %0d exp 0", bus.stall); else passed++;
    tick();
    total++; if (bus.iss_pc !== 5'd0) $display("FAIL flush_bubble_pc: got %0d exp 0", bus.iss_pc); else passed++;
    total++; if (bus.iss_reg_wrenable !== 1'b0) $display("FAIL flush_bubble_we: got %0d exp 0", bus.iss_reg_wrenable); else passed++;
    bus.ex_branch_taken = 1'b0;
    drive(1'b1, 5'd14, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd11, 1'b0);
    total++; if (bus.stall !== 1'b0) $display("FAIL flush_target_stall: got %0d exp 0", bus.stall); else passed++;
    tick();
    total++; if (bus.iss_pc !== 5'd14) $display("FAIL flush_target_pc: got %0d exp 14", bus.iss_pc); else passed++;
    idle();
    tick();
  endtask

  task automatic test_halt();
    drive(1'b1, 5'd15, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    total++; if (bus.stall !== 1'b0) $display("FAIL halt_issue_stall: got %0d exp 0", bus.stall); else passed++;
    tick();
    drive(1'b1, 5'd16, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0);
    total++; if (bus.iss_halt !== 1'b1) $display("FAIL halt_iss_halt: got %0d exp 1", bus.iss_halt); else passed++;
    total++; if (bus.iss_pc !== 5'd15) $display("FAIL halt_iss_pc: got %0d exp 15", bus.iss_pc); else passed++;
    total++; if (bus.stall !== 1'b1) $display("FAIL halt_drain_stall: got %0d exp 1", bus.stall); else passed++;
    tick();
    total++; if (bus.iss_halt !== 1'b0) $display("FAIL halt_pulse: got %0d exp 0", bus.iss_halt); else passed++;
    total++; if (bus.iss_pc !== 5'd0) $display("FAIL halt_drain_bubble: got %0d exp 0", bus.iss_pc); else passed++;
    total++; if (bus.halted !== 1'b0) $display("FAIL halt_early1: got %0d exp 0", bus.halted); else passed++;
    bus.ex_branch_taken = 1'b1;
    #1;
    total++; if (bus.stall !== 1'b1) $display("FAIL halt_drain_branch_stall: got %0d exp 1", bus.stall); else passed++;
    tick();
    bus.ex_branch_taken = 1'b0;
    total++; if (bus.halted !== 1'b0) $display("FAIL halt_early2: got %0d exp 0", bus.halted); else passed++;
    tick();
    total++; if (bus.halted !== 1'b1) $display("FAIL halt_asserted: got %0d exp 1", bus.halted); else passed++;
    total++; if (bus.stall !== 1'b1) $display("FAIL halted_stall: got %0d exp 1", bus.stall); else passed++;
    tick();
    tick();
    total++; if (bus.halted !== 1'b1) $display("FAIL halt_sticky: got %0d exp 1", bus.halted); else passed++;
    total++; if (bus.iss_reg_wrenable !== 1'b0) $display("FAIL halted_bubble: got %0d exp 0", bus.iss_reg_wrenable); else passed++;
    reset = 1'b1;
    #1;
    total++; if (bus.stall !== 1'b0) $display("FAIL halt_reset_stall: got %0d exp 0", bus.stall); else passed++;
    tick();
    total++; if (bus.halted !== 1'b0) $display("FAIL halt_reset_clear: got %0d exp 0", bus.halted); else passed++;
    idle();
    reset = 1'b0;
    #1;
    total++; if (bus.stall !== 1'b0) $display("FAIL halt_post_reset_stall: got %0d exp 0", bus.stall); else passed++;
    tick();
  endtask

  task automatic test_halt_flush();
    drive(1'b1, 5'd17, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    bus.ex_branch_taken = 1'b1;
    #1;
    total++; if (bus.stall !== 1'b0) $display("FAIL hf_stall: got %0d exp 0", bus.stall); else passed++;
    tick();
    total++; if (bus.iss_halt !== 1'b0) $display("FAIL hf_iss_halt: got %0d exp 0", bus.iss_halt); else passed++;
    total++; if (bus.iss_pc !== 5'd0) $display("FAIL hf_bubble_pc: got %0d exp 0", bus.iss_pc); else passed++;
    bus.ex_branch_taken = 1'b0;
    drive(1'b1, 5'd18, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd1, 1'b0);
    total++; if (bus.stall !== 1'b0) $display("FAIL hf_run_stall: got %0d exp 0", bus.stall); else passed++;
    tick();
    total++; if (bus.iss_pc !== 5'd18) $display("FAIL hf_next_pc: got %0d exp 18", bus.iss_pc); else passed++;
    idle();
    for (int i = 0; i < 4; i++) tick();
    total++; if (bus.halted !== 1'b0) $display("FAIL hf_never_halted: got %0d exp 0", bus.halted); else passed++;
    total++; if (bus.stall !== 1'b0) $display("FAIL hf_no_stall: got %0d exp 0", bus.stall); else passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.ex_branch_taken = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_forwarding();
    test_flush();
    test_halt();
    test_halt_flush();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
